// File: rtl/mult_collect_unit_if.sv
// Handshake bundle for the multiplier collect stage.
// Input side: in_valid/in_ready/in_re/in_im.
// Output side: out_valid/out_ready/out_re/out_im/out_idx, plus done/overflow.
interface mult_collect_unit_if #(
   parameter int DATA_W = 16,
   parameter int N_LOG2 = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_re;
   logic [DATA_W-1:0] in_im;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_re;
   logic [DATA_W-1:0] out_im;
   logic [N_LOG2-1:0] out_idx;
   logic              done;
   logic              overflow;

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im,
      input  out_idx, done, overflow
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im,
      output out_idx, done, overflow
   );
endinterface

// File: rtl/mult_collect_unit.sv
// Collects one frame of 2^N_LOG2 complex multiplier results and replays it.
// Ports: clk, rst (async high), clr (sync abort), bus (slave modport).
// Build option MULT_COLLECT_BITREV_EN: store at bit-reversed write address.
module mult_collect_unit #(
   parameter int DATA_W = 16,
   parameter int N_LOG2 = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   mult_collect_unit_if.slave bus
);
   localparam int DEPTH = 1 << N_LOG2;
   localparam logic [N_LOG2-1:0] LAST = '1;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
   logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic [N_LOG2-1:0] wr_addr;
   logic              wr_en;

   logic [2*DATA_W-1:0] mem_q [DEPTH];

`ifdef MULT_COLLECT_BITREV_EN
   // Input arrives in bit-reversed order; storing reversed yields natural.
   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < N_LOG2; i++) begin
         wr_addr[i] = wr_cnt_q[N_LOG2-1-i];
      end
   end
`else
   assign wr_addr = wr_cnt_q;
`endif

   assign bus.in_ready  = (state_q == FILL);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_idx   = rd_cnt_q;
   assign bus.out_re    = mem_q[rd_cnt_q][2*DATA_W-1:DATA_W];
   assign bus.out_im    = mem_q[rd_cnt_q][DATA_W-1:0];
   assign bus.done      = done_q;
   assign bus.overflow  = ovf_q;

   assign wr_en = (state_q == FILL) && bus.in_valid && !clr;

   // Buffer contents survive reset; only the counters are cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= {bus.in_re, bus.in_im};
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q | (bus.in_valid & ~bus.in_ready);
      if (clr) begin
         state_d  = FILL;
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         ovf_d    = ovf_q;
      end else begin
         unique case (state_q)
            FILL: begin
               if (bus.in_valid) begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
                  if (wr_cnt_q == LAST) begin
                     state_d  = DRAIN;
                     rd_cnt_d = '0;
                  end
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
                  if (rd_cnt_q == LAST) begin
                     state_d  = FILL;
                     rd_cnt_d = '0;
                     wr_cnt_d = '0;
                     done_d   = 1'b1;
                  end
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FILL;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule

// File: doc/mult_collect_unit.md
Name: mult_collect_unit

Overview:
- Receiving end of the multiplier stage in the 64-point FFT datapath.
- Captures one frame of 2^N_LOG2 complex multiplier results, presented one per cycle under a valid strobe, into an internal frame buffer.
- Once the frame is complete, replays it in natural index order over a valid/ready handshake to the downstream stage.
- Pulses done when the frame has been fully drained.

Parameters:
DATA_W, 16, width of each real and imaginary sample
N_LOG2, 6, log2 of frame length (frame = 64 samples by default)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous abort; return to FILL, counters cleared
in_valid  input  1  sample present on in_re/in_im
in_ready  output  1  block accepts samples (high only in FILL)
in_re  input  DATA_W  real part of multiplier result
in_im  input  DATA_W  imaginary part of multiplier result
out_valid  output  1  out_re/out_im/out_idx valid
out_ready  input  1  downstream accepts current sample
out_re  output  DATA_W  real part, buffer[rd_cnt]
out_im  output  DATA_W  imaginary part, buffer[rd_cnt]
out_idx  output  N_LOG2  natural-order index of current output sample
done  output  1  one-cycle pulse after last sample of frame drained
overflow  output  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset (rst high, asynchronous): state=FILL, wr_cnt=0, rd_cnt=0, out_valid=0, done=0, overflow=0. Buffer contents are not reset.
- Reset mid-frame discards partial frame. Output is idle the cycle after rst deasserts.
- Two states: FILL and DRAIN. in_ready = (state==FILL). out_valid = (state==DRAIN).
- FILL:
  - Each cycle with in_valid=1 writes {in_re,in_im} at wr_addr(wr_cnt), then wr_cnt increments modulo 2^N_LOG2.
  - The write that takes wr_cnt from 2^N_LOG2-1 to 0 moves state to DRAIN on the next edge, with rd_cnt=0.
  - in_valid=0 holds wr_cnt; gaps are allowed.
- DRAIN:
  - out_re/out_im = buffer[rd_cnt], read combinationally from the register array. out_idx = rd_cnt.
  - A transfer occurs when out_valid & out_ready; rd_cnt increments.
  - out_ready=0 holds all outputs stable.
  - Transfer at rd_cnt=2^N_LOG2-1: next edge sets state=FILL, rd_cnt=0, wr_cnt=0, done=1 for exactly one cycle.
  - First sample of the next frame may be accepted in the same cycle done is high.
- Latency: first out_valid is one cycle after the last input write. Min frame period is 2·2^N_LOG2 cycles.
- overflow: set when in_valid=1 and in_ready=0. Sample is dropped, no state change. Cleared only by rst.
- clr (synchronous):
  - Forces state=FILL, wr_cnt=0, rd_cnt=0, done=0. overflow is unchanged.
  - Takes priority over every in-cycle write or transfer.
- Counters are N_LOG2 bits, unsigned, wrapping modulo 2^N_LOG2.
- Simultaneous in_valid during DRAIN's final transfer cycle counts as overflow, because in_ready is still low that cycle.

Optional Feature:
- Macro MULT_COLLECT_BITREV_EN.
- Defined: wr_addr(wr_cnt) = bit-reverse of wr_cnt over N_LOG2 bits. Input is in bit-reversed order, output in natural order; e.g., input sample 1 is stored at address 32 when N_LOG2=6.
- Undefined: wr_addr(wr_cnt) = wr_cnt. Output order equals input order.
- Nothing else differs between the two builds.

Test Plan:
- Reset then idle: rst=1 → in_ready=1, out_valid=0, done=0, overflow=0. Hold 10 cycles after release → no change.
- Full frame, out_ready=1 always, in_re=k, in_im=-k for k=0..63 on 64 consecutive cycles. Without macro: out_re=0..63 in order, first out_valid one cycle after k=63 write, done pulses once after idx 63. With MULT_COLLECT_BITREV_EN: out_re at out_idx=j equals bitrev6(j), e.g., idx 1 → 32.
- Backpressure: out_ready toggled 1,0,0,1,… during DRAIN → each sample emitted exactly once, outputs stable while out_ready=0, exactly 64 transfers, single done.
- Overflow: in_valid=1 held through DRAIN → overflow rises on first DRAIN cycle and stays 1 across the next frame; drained data unaffected.
- clr mid-FILL at wr_cnt=20, then a full 64-sample frame → output is exactly the new 64 samples. clr mid-DRAIN at rd_cnt=10 → out_valid low next cycle, no done pulse.
- Async rst asserted mid-DRAIN between clock edges → outputs reach reset values immediately. Next frame after release drains correctly.
